hazard_ctrl: RTL and testbench

- Parametrised successor to the pipeline hazard unit for the 5-stage MIPS core.
- Keeps EX-stage forwarding and load-use interlock; adds:
  - ID-stage branch forwarding and branch interlock;
  - a sequencer that freezes the pipe for a multi-cycle divider;
  - exception flush with divider abort;
  - a saturating stall-cycle performance counter.
- Sits beside the datapath. It drives all stall, flush and forward selects.

---
 rtl/hazard_pkg.sv | 14 +
 rtl/hazard_div_seq.sv | 58 +++++
 rtl/hazard_ctrl.sv | 113 +++++++++++
 tb/tb_hazard_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

endpackage

// File: rtl/hazard_div_seq.sv
// Divider sequencer: freezes the pipe while a multi-cycle divide is in flight.
module hazard_div_seq
  import hazard_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic divStart,
  input  logic except,
  output logic divStall,
  output logic divBusy
);

  localparam logic [7:0] CNT_LOAD = 8'(DIV_CYCLES - 1);

  div_state_t state, stateNxt;
  logic [7:0] cnt, cntNxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNxt;
      cnt   <= cntNxt;
    end
  end

  // The exit test looks at the decremented count, so the start cycle plus
  // DIV_CYCLES-1 BUSY cycles give a stall of exactly DIV_CYCLES cycles.
  always_comb begin
    stateNxt = state;
    cntNxt   = cnt;
    case (state)
      IDLE: begin
        if (divStart) begin
          stateNxt = BUSY;
          cntNxt   = CNT_LOAD;
        end
      end
      BUSY: begin
        cntNxt = cnt - 8'd1;
        if (cntNxt == '0) stateNxt = DONE;
      end
      DONE:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
    if (except) begin
      stateNxt = IDLE;
      cntNxt   = '0;
    end
  end

  assign divStall = ((state == IDLE) && divStart) || (state == BUSY);
  assign divBusy  = (state != IDLE);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: forwarding, interlocks, divider
// freeze, exception flush and a saturating stall-cycle counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic              branchD,
  input  logic [REG_AW-1:0] rsE,
  input  logic [REG_AW-1:0] rtE,
  input  logic [REG_AW-1:0] writeregE,
  input  logic              regwriteE,
  input  logic              memtoregE,
  input  logic              div_startE,
  input  logic [REG_AW-1:0] writeregM,
  input  logic              regwriteM,
  input  logic              memtoregM,
  input  logic              exceptM,
  input  logic [REG_AW-1:0] writeregW,
  input  logic              regwriteW,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              flushD,
  output logic              flushE,
  output logic              flushM,
  output logic              flushW,
  output logic [1:0]        forwardaE,
  output logic [1:0]        forwardbE,
  output logic              forwardaD,
  output logic              forwardbD,
  output logic              div_busy,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic divStall, lwStall, brStall;
  logic hitE, hitM;

  hazard_div_seq #(.DIV_CYCLES(DIV_CYCLES)) uDivSeq (
    .clk      (clk),
    .rst      (rst),
    .divStart (div_startE),
    .except   (exceptM),
    .divStall (divStall),
    .divBusy  (div_busy)
  );

  always_comb begin
    forwardaE = FWD_RF;
    if (rsE != '0) begin
      if (regwriteM && (rsE == writeregM))      forwardaE = FWD_MEM;
      else if (regwriteW && (rsE == writeregW)) forwardaE = FWD_WB;
    end
  end

  always_comb begin
    forwardbE = FWD_RF;
    if (rtE != '0) begin
      if (regwriteM && (rtE == writeregM))      forwardbE = FWD_MEM;
      else if (regwriteW && (rtE == writeregW)) forwardbE = FWD_WB;
    end
  end

  assign forwardaD = (rsD != '0) && regwriteM && (rsD == writeregM);
  assign forwardbD = (rtD != '0) && regwriteM && (rtD == writeregM);

  assign hitE    = (writeregE != '0) && ((writeregE == rsD) || (writeregE == rtD));
  assign hitM    = (writeregM != '0) && ((writeregM == rsD) || (writeregM == rtD));
  assign lwStall = memtoregE && hitE;
  assign brStall = branchD && ((regwriteE && hitE) || (memtoregM && hitM));

  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushM = 1'b0;
    flushW = 1'b0;
    if (!rst) begin
      stallF = 1'b0;
    end else if (exceptM) begin
      flushD = 1'b1;
      flushE = 1'b1;
      flushM = 1'b1;
      flushW = 1'b1;
    end else if (divStall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      flushM = 1'b1;
    end else if (lwStall || brStall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stallF && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboarded random bench for hazard_ctrl against a cycle-level reference model.
module tb_hazard_ctrl;

  localparam int DIVC = 4;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  typedef struct {
    logic       rst;
    logic [4:0] rsD, rtD;
    logic       branchD;
    logic [4:0] rsE, rtE, writeregE;
    logic       regwriteE, memtoregE, div_startE;
    logic [4:0] writeregM;
    logic       regwriteM, memtoregM, exceptM;
    logic [4:0] writeregW;
    logic       regwriteW;
  } stim_t;

  typedef struct {
    logic          stallF, stallD, stallE;
    logic          flushD, flushE, flushM, flushW;
    logic [1:0]    fAE, fBE;
    logic          fAD, fBD, busy;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4:0] rsD = '0, rtD = '0, rsE = '0, rtE = '0, writeregE = '0, writeregM = '0, writeregW = '0;
  logic branchD = 1'b0, regwriteE = 1'b0, memtoregE = 1'b0, div_startE = 1'b0;
  logic regwriteM = 1'b0, memtoregM = 1'b0, exceptM = 1'b0, regwriteW = 1'b0;
  logic stallF, stallD, stallE, flushD, flushE, flushM, flushW;
  logic [1:0] forwardaE, forwardbE;
  logic forwardaD, forwardbD, div_busy;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(5), .DIV_CYCLES(DIVC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .rsD(rsD), .rtD(rtD), .branchD(branchD),
    .rsE(rsE), .rtE(rtE), .writeregE(writeregE),
    .regwriteE(regwriteE), .memtoregE(memtoregE), .div_startE(div_startE),
    .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM),
    .exceptM(exceptM), .writeregW(writeregW), .regwriteW(regwriteW),
    .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .forwardaE(forwardaE), .forwardbE(forwardbE),
    .forwardaD(forwardaD), .forwardbD(forwardbD),
    .div_busy(div_busy), .stall_cnt(stall_cnt)
  );

  exp_t expQ[$];
  int   passed = 0;
  int   total  = 0;

  // Reference state: age of the current divide (-1 = none, 1..DIVC) and stall count.
  int mAge = -1;
  int mCnt = 0;

  function automatic logic [1:0] fwdSel(input logic [4:0] r, input stim_t s);
    if (r == 0) return 2'b00;
    if (s.regwriteM && r == s.writeregM) return 2'b10;
    if (s.regwriteW && r == s.writeregW) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic usesReg(input logic [4:0] r, input stim_t s);
    return (r != 0) && (r == s.rsD || r == s.rtD);
  endfunction

  function automatic stim_t quiet();
    stim_t s;
    s = '{default: '0};
    s.rst = 1'b1;
    return s;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    logic lw, br, divSt;
    @(posedge clk);
    #2;
    rst = s.rst; rsD = s.rsD; rtD = s.rtD; branchD = s.branchD;
    rsE = s.rsE; rtE = s.rtE; writeregE = s.writeregE;
    regwriteE = s.regwriteE; memtoregE = s.memtoregE; div_startE = s.div_startE;
    writeregM = s.writeregM; regwriteM = s.regwriteM; memtoregM = s.memtoregM;
    exceptM = s.exceptM; writeregW = s.writeregW; regwriteW = s.regwriteW;

    e = '{default: '0};
    e.fAE = fwdSel(s.rsE, s);
    e.fBE = fwdSel(s.rtE, s);
    e.fAD = (s.rsD != 0) && s.regwriteM && (s.rsD == s.writeregM);
    e.fBD = (s.rtD != 0) && s.regwriteM && (s.rtD == s.writeregM);
    lw    = s.memtoregE && usesReg(s.writeregE, s);
    br    = s.branchD && ((s.regwriteE && usesReg(s.writeregE, s)) ||
                          (s.memtoregM && usesReg(s.writeregM, s)));
    divSt = (mAge < 0 && s.div_startE) || (mAge >= 1 && mAge < DIVC);
    if (!s.rst) begin
      mAge = -1;
      mCnt = 0;
    end
    e.busy = (mAge >= 1);
    e.cnt  = CW'(mCnt);
    if (s.rst) begin
      if (s.exceptM) begin
        e.flushD = 1; e.flushE = 1; e.flushM = 1; e.flushW = 1;
      end else if (divSt) begin
        e.stallF = 1; e.stallD = 1; e.stallE = 1; e.flushM = 1;
      end else if (lw || br) begin
        e.stallF = 1; e.stallD = 1; e.flushE = 1;
      end
    end
    expQ.push_back(e);

    if (s.rst) begin
      if (e.stallF && mCnt < MAXC) mCnt++;
      if (s.exceptM)        mAge = -1;
      else if (mAge < 0)    mAge = s.div_startE ? 1 : -1;
      else if (mAge < DIVC) mAge++;
      else                  mAge = -1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        chk("stallF", 32'(stallF), 32'(e.stallF));
        chk("stallD", 32'(stallD), 32'(e.stallD));
        chk("stallE", 32'(stallE), 32'(e.stallE));
        chk("flushD", 32'(flushD), 32'(e.flushD));
        chk("flushE", 32'(flushE), 32'(e.flushE));
        chk("flushM", 32'(flushM), 32'(e.flushM));
        chk("flushW", 32'(flushW), 32'(e.flushW));
        chk("forwardaE", 32'(forwardaE), 32'(e.fAE));
        chk("forwardbE", 32'(forwardbE), 32'(e.fBE));
        chk("forwardaD", 32'(forwardaD), 32'(e.fAD));
        chk("forwardbD", 32'(forwardbD), 32'(e.fBD));
        chk("div_busy", 32'(div_busy), 32'(e.busy));
        chk("stall_cnt", 32'(stall_cnt), 32'(e.cnt));
      end
    end
  end

  initial begin : driver
    stim_t s;
    int budget;
    s = quiet(); s.rst = 0;
    repeat (2) step(s);

    // forwarding priority
    s = quiet(); s.rsE = 3; s.writeregM = 3; s.regwriteM = 1; s.writeregW = 3; s.regwriteW = 1;
    step(s);
    s.regwriteM = 0; step(s);
    s.rsE = 0;       step(s);

    // load-use, then destination zero
    s = quiet(); s.memtoregE = 1; s.writeregE = 8; s.rtD = 8; step(s);
    s.writeregE = 0; step(s);

    // branch on EX producer, then producer in MEM
    s = quiet(); s.branchD = 1; s.rsD = 5; s.regwriteE = 1; s.writeregE = 5; step(s);
    s = quiet(); s.branchD = 1; s.rsD = 5; s.regwriteM = 1; s.writeregM = 5; step(s);

    // divide held through the stall with a concurrent load-use condition
    s = quiet(); s.div_startE = 1; s.memtoregE = 1; s.writeregE = 7; s.rsD = 7;
    repeat (DIVC + 1) step(s);
    s = quiet(); repeat (2) step(s);

    // exception on the second BUSY cycle
    s = quiet(); s.div_startE = 1;
    repeat (2) step(s);
    s.exceptM = 1; step(s);
    s = quiet(); repeat (2) step(s);

    // reset mid-BUSY, then release
    s = quiet(); s.div_startE = 1; repeat (2) step(s);
    s.rst = 0; step(s);
    s.rst = 1; repeat (DIVC + 2) step(s);

    // long divide chain drives the counter into saturation
    s = quiet(); s.div_startE = 1; repeat (20) step(s);

    for (int i = 0; i < 800; i++) begin
      s.rst        = ($urandom_range(0, 59) != 0);
      s.rsD        = 5'($urandom_range(0, 3));
      s.rtD        = 5'($urandom_range(0, 3));
      s.branchD    = ($urandom_range(0, 3) == 0);
      s.rsE        = 5'($urandom_range(0, 3));
      s.rtE        = 5'($urandom_range(0, 3));
      s.writeregE  = 5'($urandom_range(0, 3));
      s.regwriteE  = 1'($urandom_range(0, 1));
      s.memtoregE  = ($urandom_range(0, 3) == 0);
      s.div_startE = ($urandom_range(0, 7) == 0);
      s.writeregM  = 5'($urandom_range(0, 3));
      s.regwriteM  = 1'($urandom_range(0, 1));
      s.memtoregM  = ($urandom_range(0, 3) == 0);
      s.exceptM    = ($urandom_range(0, 19) == 0);
      s.writeregW  = 5'($urandom_range(0, 3));
      s.regwriteW  = 1'($urandom_range(0, 1));
      step(s);
    end

    budget = 20;
    while (expQ.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    @(negedge clk);
    #1;
    if (expQ.size() > 0) begin
      total++;
      $display("FAIL drain: got %0d pending expected 0", expQ.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
